// File: rtl/usb_bus_ctrl_if.sv
// Bus-state signal bundle between the USB line decoder / reset detector and the
// bus-state controller. The master side drives line information, the slave side reports state.
interface usb_bus_ctrl_if;
    logic       bus_reset;
    logic [1:0] line_state;
    logic       remote_wakeup_en;
    logic       wakeup_req;
    logic       suspend;
    logic       resume_pulse;
    logic       drive_k;
    logic [2:0] state;

    modport master (
        output bus_reset, line_state, remote_wakeup_en, wakeup_req,
        input  suspend, resume_pulse, drive_k, state
    );

    modport slave (
        input  bus_reset, line_state, remote_wakeup_en, wakeup_req,
        output suspend, resume_pulse, drive_k, state
    );
endinterface

// File: rtl/usb_bus_ctrl.sv
// USB device bus-state controller: suspend detection, host resume detection and
// remote-wakeup K signalling, with bus reset overriding every state.
module usb_bus_ctrl #(
    parameter int T_SUSPEND_US   = 3000,
    parameter int T_WAKE_IDLE_US = 5000,
    parameter int T_DRIVE_K_US   = 2000,
    parameter int T_K_FILT_US    = 3
) (
    input  logic           clk,
    input  logic           reset_ni,
    input  logic           usb_full_speed,
    usb_bus_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_ACTIVE      = 3'd0,
        ST_SUSPENDED   = 3'd1,
        ST_RESUME_HOST = 3'd2,
        ST_WAKE_DRIVE  = 3'd3,
        ST_WAKE_WAIT   = 3'd4,
        ST_BUS_RESET   = 3'd5
    } state_e;

    localparam logic [15:0] T_SUSPEND_C   = 16'(T_SUSPEND_US);
    localparam logic [15:0] T_WAKE_IDLE_C = 16'(T_WAKE_IDLE_US);
    localparam logic [15:0] T_DRIVE_K_C   = 16'(T_DRIVE_K_US);
    localparam logic [15:0] T_K_FILT_C    = 16'(T_K_FILT_US);

    // Saturating increment used by every microsecond timer.
    function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic en);
        if (en && (value != 16'hFFFF)) begin
            return value + 16'd1;
        end else begin
            return value;
        end
    endfunction

    logic [5:0]  presc_r;
    logic [5:0]  presc_max_s;
    logic        tick_s;
    logic [15:0] idle_tmr_r;
    logic [15:0] state_tmr_r;
    logic [15:0] kfilt_tmr_r;
    logic        line_se0_s;
    logic        line_j_s;
    logic        line_k_s;
    logic        clr_idle_s;
    state_e      state_r;
    state_e      state_next_s;
    logic        suspend_s;
    logic        resume_pulse_s;
    logic        drive_k_s;
    logic        suspend_r;
    logic        resume_pulse_r;
    logic        drive_k_r;

    assign line_se0_s  = (bus.line_state == 2'b00);
    assign line_j_s    = (bus.line_state == 2'b01);
    assign line_k_s    = (bus.line_state == 2'b10);
    assign presc_max_s = usb_full_speed ? 6'd47 : 6'd5;
    // >= rather than == keeps the prescaler bounded if it ever holds an out-of-range count.
    assign tick_s      = (presc_r >= presc_max_s);
    assign clr_idle_s  = (state_r == ST_BUS_RESET) && (state_next_s == ST_ACTIVE);

    // Free-running microsecond prescaler.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            presc_r <= 6'd0;
        end else if (tick_s) begin
            presc_r <= 6'd0;
        end else begin
            presc_r <= presc_r + 6'd1;
        end
    end

    // Continuous-J idle timer; also serves as the J filter while in RESUME_HOST.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            idle_tmr_r <= 16'd0;
        end else if (!line_j_s || clr_idle_s) begin
            idle_tmr_r <= 16'd0;
        end else begin
            idle_tmr_r <= sat_inc(idle_tmr_r, tick_s);
        end
    end

    // Time spent in the current state, restarted on every transition.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_tmr_r <= 16'd0;
        end else if (state_next_s != state_r) begin
            state_tmr_r <= 16'd0;
        end else begin
            state_tmr_r <= sat_inc(state_tmr_r, tick_s);
        end
    end

    // Continuous-K filter for host resume detection.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            kfilt_tmr_r <= 16'd0;
        end else if (!line_k_s) begin
            kfilt_tmr_r <= 16'd0;
        end else begin
            kfilt_tmr_r <= sat_inc(kfilt_tmr_r, tick_s);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r <= ST_ACTIVE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; bus reset pre-empts everything, K expiry beats wakeup_req.
    always_comb begin
        state_next_s = state_r;
        if (bus.bus_reset) begin
            state_next_s = ST_BUS_RESET;
        end else begin
            case (state_r)
                ST_ACTIVE: begin
                    if (idle_tmr_r >= T_SUSPEND_C) begin
                        state_next_s = ST_SUSPENDED;
                    end else begin
                        state_next_s = ST_ACTIVE;
                    end
                end
                ST_SUSPENDED: begin
                    if (kfilt_tmr_r >= T_K_FILT_C) begin
                        state_next_s = ST_RESUME_HOST;
                    end else if (bus.wakeup_req && bus.remote_wakeup_en &&
                                 (state_tmr_r >= T_WAKE_IDLE_C)) begin
                        state_next_s = ST_WAKE_DRIVE;
                    end else begin
                        state_next_s = ST_SUSPENDED;
                    end
                end
                ST_RESUME_HOST: begin
                    if (line_se0_s) begin
                        state_next_s = ST_ACTIVE;
                    end else if (idle_tmr_r >= T_K_FILT_C) begin
                        state_next_s = ST_SUSPENDED;
                    end else begin
                        state_next_s = ST_RESUME_HOST;
                    end
                end
                ST_WAKE_DRIVE: begin
                    if (state_tmr_r >= T_DRIVE_K_C) begin
                        state_next_s = ST_WAKE_WAIT;
                    end else begin
                        state_next_s = ST_WAKE_DRIVE;
                    end
                end
                ST_WAKE_WAIT: begin
                    if (line_se0_s) begin
                        state_next_s = ST_ACTIVE;
                    end else begin
                        state_next_s = ST_WAKE_WAIT;
                    end
                end
                ST_BUS_RESET: begin
                    state_next_s = ST_ACTIVE;
                end
                default: begin
                    state_next_s = ST_ACTIVE;
                end
            endcase
        end
    end

    // Output decode from the next state so registered outputs line up with state_r.
    always_comb begin
        suspend_s      = 1'b0;
        drive_k_s      = 1'b0;
        resume_pulse_s = 1'b0;
        case (state_next_s)
            ST_SUSPENDED, ST_RESUME_HOST, ST_WAKE_WAIT: begin
                suspend_s = 1'b1;
            end
            ST_WAKE_DRIVE: begin
                suspend_s = 1'b1;
                drive_k_s = 1'b1;
            end
            ST_ACTIVE: begin
                if ((state_r == ST_RESUME_HOST) || (state_r == ST_WAKE_WAIT)) begin
                    resume_pulse_s = 1'b1;
                end else begin
                    resume_pulse_s = 1'b0;
                end
            end
            default: begin
                suspend_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            suspend_r      <= 1'b0;
            drive_k_r      <= 1'b0;
            resume_pulse_r <= 1'b0;
        end else begin
            suspend_r      <= suspend_s;
            drive_k_r      <= drive_k_s;
            resume_pulse_r <= resume_pulse_s;
        end
    end

    assign bus.state        = state_r;
    assign bus.suspend      = suspend_r;
    assign bus.drive_k      = drive_k_r;
    assign bus.resume_pulse = resume_pulse_r;

endmodule

// File: tb/tb_usb_bus_ctrl.sv
// Directed bench for usb_bus_ctrl with shortened timing parameters (microseconds
// scaled down so the run stays short); expected values are hand-derived.
module tb_usb_bus_ctrl;
    localparam int T_SUSP = 20;
    localparam int T_WAKE = 30;
    localparam int T_DRV  = 10;
    localparam int T_KF   = 3;
    localparam int FS     = 48;
    localparam int LS     = 6;

    logic clk = 1'b0;
    logic reset_ni = 1'b0;
    logic usb_full_speed = 1'b1;

    usb_bus_ctrl_if bus_if();

    usb_bus_ctrl #(
        .T_SUSPEND_US  (T_SUSP),
        .T_WAKE_IDLE_US(T_WAKE),
        .T_DRIVE_K_US  (T_DRV),
        .T_K_FILT_US   (T_KF)
    ) dut (
        .clk           (clk),
        .reset_ni      (reset_ni),
        .usb_full_speed(usb_full_speed),
        .bus           (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_fail    = 0;
    int pulse_cnt = 0;
    int dk_cnt    = 0;
    int sus_cnt   = 0;
    int took;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clocks, sampling 1 time unit after each rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.resume_pulse) pulse_cnt++;
            if (bus_if.drive_k)      dk_cnt++;
            if (bus_if.suspend)      sus_cnt++;
        end
    endtask

    task automatic wait_suspend(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            step(1);
            if (bus_if.suspend) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic wait_state(input int st, input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            step(1);
            if (int'(bus_if.state) == st) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic pulse_req();
        bus_if.wakeup_req = 1'b1;
        step(1);
        bus_if.wakeup_req = 1'b0;
    endtask

    initial begin
        bus_if.bus_reset        = 1'b0;
        bus_if.line_state       = 2'b01;
        bus_if.remote_wakeup_en = 1'b0;
        bus_if.wakeup_req       = 1'b0;
        step(3);
        check("rst_state",   int'(bus_if.state), 0);
        check("rst_suspend", int'(bus_if.suspend), 0);
        check("rst_resume",  int'(bus_if.resume_pulse), 0);
        check("rst_drive_k", int'(bus_if.drive_k), 0);

        // Full speed: continuous J enters suspend after T_SUSP us
        reset_ni = 1'b1;
        wait_suspend(3000, took);
        check($sformatf("fs_suspend_time(%0d)", took),
              int'(took >= (T_SUSP - 1) * FS && took <= (T_SUSP + 1) * FS), 1);
        check("fs_suspend_state", int'(bus_if.state), 1);

        // Host resume: K, then SE0 EOP, then J
        bus_if.line_state = 2'b10;
        step(10 * FS);
        check("fs_resume_host_state", int'(bus_if.state), 2);
        check("fs_resume_host_susp", int'(bus_if.suspend), 1);
        bus_if.line_state = 2'b00;
        pulse_cnt = 0;
        step(1);
        check("fs_rp_at_se0", int'(bus_if.resume_pulse), 1);
        step(63);
        bus_if.line_state = 2'b01;
        step(10);
        check("fs_rp_count", pulse_cnt, 1);
        check("fs_active_state", int'(bus_if.state), 0);
        check("fs_active_susp", int'(bus_if.suspend), 0);

        // Remote wakeup after more than T_WAKE us suspended
        wait_suspend(3000, took);
        check("fs_resuspend", int'(took > 0), 1);
        step((T_WAKE + 5) * FS);
        bus_if.remote_wakeup_en = 1'b1;
        dk_cnt = 0;
        pulse_req();
        check("fs_wake_drive_state", int'(bus_if.state), 3);
        wait_state(4, 2000, took);
        check("fs_wake_wait_reached", int'(took > 0), 1);
        check($sformatf("fs_drive_k_len(%0d)", dk_cnt),
              int'(dk_cnt >= (T_DRV - 1) * FS && dk_cnt <= (T_DRV + 1) * FS), 1);
        check("fs_wake_wait_dk", int'(bus_if.drive_k), 0);
        bus_if.line_state = 2'b10;
        step(5 * FS);
        check("fs_wake_wait_hold", int'(bus_if.state), 4);
        bus_if.line_state = 2'b00;
        pulse_cnt = 0;
        step(1);
        check("fs_wake_rp", int'(bus_if.resume_pulse), 1);
        step(20);
        bus_if.line_state = 2'b01;
        step(5);
        check("fs_wake_rp_count", pulse_cnt, 1);
        check("fs_wake_active", int'(bus_if.state), 0);

        // Wakeup too early, then with feature disabled: request dropped
        wait_suspend(3000, took);
        check("fs_suspend3", int'(took > 0), 1);
        step(5 * FS);
        dk_cnt = 0;
        pulse_req();
        step(50);
        check("fs_early_wake_state", int'(bus_if.state), 1);
        bus_if.remote_wakeup_en = 1'b0;
        step((T_WAKE + 5) * FS);
        pulse_req();
        step(50);
        check("fs_wake_disabled_state", int'(bus_if.state), 1);
        bus_if.remote_wakeup_en = 1'b1;
        step(100);
        check("fs_wake_not_queued", int'(bus_if.state), 1);
        check("fs_no_drive_k", dk_cnt, 0);

        // Bus reset during WAKE_DRIVE
        pulse_req();
        step(100);
        check("fs_wd_state", int'(bus_if.state), 3);
        check("fs_wd_drive_k", int'(bus_if.drive_k), 1);
        bus_if.bus_reset = 1'b1;
        step(1);
        check("fs_br_drive_k", int'(bus_if.drive_k), 0);
        check("fs_br_state", int'(bus_if.state), 5);
        check("fs_br_suspend", int'(bus_if.suspend), 0);
        step(20);
        bus_if.bus_reset = 1'b0;
        pulse_cnt = 0;
        step(1);
        check("fs_br_release_state", int'(bus_if.state), 0);
        step(20);
        check("fs_br_no_rp", pulse_cnt, 0);
        check("fs_br_release_susp", int'(bus_if.suspend), 0);

        // Low speed
        reset_ni = 1'b0;
        usb_full_speed = 1'b0;
        bus_if.remote_wakeup_en = 1'b0;
        step(3);
        reset_ni = 1'b1;
        wait_suspend(400, took);
        check($sformatf("ls_suspend_time(%0d)", took),
              int'(took >= (T_SUSP - 1) * LS && took <= (T_SUSP + 1) * LS), 1);
        bus_if.line_state = 2'b10;
        step(LS);
        bus_if.line_state = 2'b01;
        step(60);
        check("ls_k_glitch", int'(bus_if.state), 1);
        bus_if.line_state = 2'b10;
        step(30);
        check("ls_resume_host", int'(bus_if.state), 2);
        bus_if.line_state = 2'b01;
        step(24);
        check("ls_j_back_to_susp", int'(bus_if.state), 1);
        bus_if.line_state = 2'b10;
        step(30);
        bus_if.line_state = 2'b00;
        step(8);
        bus_if.line_state = 2'b01;
        step(2);
        check("ls_resume_active", int'(bus_if.state), 0);

        // Periodic activity (SE0 / SE1) keeps the bus out of suspend
        sus_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            bus_if.line_state = 2'b01;
            step(15 * LS);
            bus_if.line_state = (k % 2 == 0) ? 2'b00 : 2'b11;
            step(2);
        end
        check("ls_activity_no_suspend", sus_cnt, 0);
        bus_if.line_state = 2'b01;
        step((T_SUSP + 5) * LS);
        check("ls_final_suspend", int'(bus_if.suspend), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_bus_ctrl.md
Name: usb_bus_ctrl

Overview:
- Bus-state controller for the USB device core; sits between the PHY line-state decoder, `usb_reset` and the protocol engine.
- Sequences the device through active, suspended and resume states.
- Detects host-driven resume and performs device remote-wakeup signalling, driving K via the PHY output enable.
- Bus reset, as detected by `usb_reset`, overrides every state.

Parameters:
- T_SUSPEND_US, 3000, continuous J idle (µs) before entering suspend
- T_WAKE_IDLE_US, 5000, minimum time suspended (µs) before remote wakeup is allowed
- T_DRIVE_K_US, 2000, duration (µs) of device-driven K during remote wakeup
- T_K_FILT_US, 3, minimum continuous K (µs) accepted as host resume

Ports:
- clk, input, 1: system clock, 4× bit rate (48 MHz full speed, 6 MHz low speed)
- reset_ni, input, 1: asynchronous active-low reset
- usb_full_speed, input, 1: 1 = full speed, 0 = low speed; static after reset
- bus_reset, input, 1: level from `usb_reset`, high while SE0 reset is detected
- line_state, input, 2: decoded bus state: 00 SE0, 01 J, 10 K, 11 SE1
- remote_wakeup_en, input, 1: DEVICE_REMOTE_WAKEUP feature set by host
- wakeup_req, input, 1: single-cycle request from application to wake the host
- suspend, output, 1: high while device is suspended
- resume_pulse, output, 1: single-cycle pulse when the bus returns to active from suspend
- drive_k, output, 1: PHY output enable with K forced on the bus
- state, output, 3: current FSM state code, for debug

Behaviour:
- Reset: all counters 0; state = ACTIVE; suspend = 0; resume_pulse = 0; drive_k = 0. All outputs are registered.
- µs tick:
  - Free-running prescaler counts 0..47 (full speed) or 0..5 (low speed).
  - `tick` is high for one cycle when the count wraps.
  - All timers advance on `tick` only, so timing resolution is ±1 µs.
- Idle timer (16 bit):
  - Cleared on any cycle with line_state != 01.
  - Otherwise increments on tick and saturates at 0xFFFF.
- State timer (16 bit): cleared on every state transition; increments on tick; saturates.
- K filter timer: cleared when line_state != 10; increments on tick while line_state == 10.
- State encoding: ACTIVE = 0, SUSPENDED = 1, RESUME_HOST = 2, WAKE_DRIVE = 3, WAKE_WAIT = 4, BUS_RESET = 5.
- Transitions (bus_reset has highest priority in every state):
  - Any state, bus_reset = 1 → BUS_RESET. drive_k drops the same cycle the state register updates.
  - BUS_RESET, bus_reset = 0 → ACTIVE. Idle timer cleared.
  - ACTIVE, idle timer == T_SUSPEND_US → SUSPENDED.
  - SUSPENDED, K filter == T_K_FILT_US → RESUME_HOST.
  - SUSPENDED, wakeup_req && remote_wakeup_en && state timer >= T_WAKE_IDLE_US → WAKE_DRIVE.
    - wakeup_req in any other case is dropped, not queued.
    - If both K-filter expiry and wakeup_req occur in the same cycle, RESUME_HOST wins.
  - RESUME_HOST, line_state == 00 (EOP after host K) → ACTIVE, with resume_pulse.
    - A glitch back to J without SE0 returns to SUSPENDED after T_K_FILT_US of J.
  - WAKE_DRIVE, state timer == T_DRIVE_K_US → WAKE_WAIT. drive_k = 1 only in WAKE_DRIVE.
  - WAKE_WAIT (host now drives K, ≥ 20 ms), line_state == 00 → ACTIVE, with resume_pulse.
- suspend is 1 in SUSPENDED, RESUME_HOST, WAKE_DRIVE and WAKE_WAIT; 0 in ACTIVE and BUS_RESET.
- resume_pulse: exactly one cycle, on the cycle state enters ACTIVE from RESUME_HOST or WAKE_WAIT. It does not fire from BUS_RESET.
- SE1 (11) is treated as non-J and non-K: it clears the idle and K filter timers and causes no transition.
- Changing usb_full_speed mid-operation is not supported; behaviour is undefined until the next reset.

Test Plan:
- Full speed. Release reset, hold line_state = 01 for 3.1 ms → suspend rises between 2999 and 3001 µs after J start; state = 1.
- Full speed, suspended. line_state = 10 for 20 ms, then 00 for 1.33 µs, then 01 → resume_pulse high for one clk at the SE0 cycle+1; suspend = 0; state = 0.
- Suspended 6 ms, remote_wakeup_en = 1, pulse wakeup_req → drive_k = 1 for 2000 ±1 µs; state 3 → 4. Host K then SE0 → ACTIVE with resume_pulse.
- Suspended 2 ms (below 5 ms) with wakeup_req, or remote_wakeup_en = 0 → drive_k stays 0; state stays 1.
- In WAKE_DRIVE, assert bus_reset → drive_k = 0 immediately; state = 5. On release → state = 0; suspend = 0; no resume_pulse.
- Low speed (clk 6 MHz). 1 µs K glitch while suspended → no transition. 500 µs idle J with activity every 1 ms → never suspends.
